// File: rtl/array_div_seq.sv
`default_nettype none
// ============================================================================
// Module      : array_div_seq
// Description : Sequential restoring divider, 8-bit dividend / 4-bit divisor,
//               one quotient bit per clock, MSB first. Optional overflow flag
//               enabled by defining ARRAY_DIV_OVF_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module array_div_seq (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] dividend,
    input  logic [3:0] divisor,
    output logic       busy,
    output logic       done,
    output logic [7:0] quotient,
    output logic [3:0] remainder,
    output logic       dbz,
    output logic       ovf
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t     r_state;
    state_t     w_next;

    logic [7:0] r_dvd;
    logic [3:0] r_dsr;
    logic [3:0] r_rem;
    logic [7:0] r_quo;
    logic [2:0] r_cnt;
    logic       r_zero;
    logic       r_done;
    logic [7:0] r_quotient;
    logic [3:0] r_remainder;
    logic       r_dbz;

    logic       w_accept;
    logic [4:0] w_rem_next;
    logic       w_ge;
    logic [3:0] w_sub;

    // DONE accepts a new request exactly like IDLE so back-to-back ops lose no cycle
    assign w_accept   = start && ((r_state == S_IDLE) || (r_state == S_DONE));

    // Difference is < divisor whenever it is used, so 4-bit modular subtract is exact
    assign w_rem_next = {r_rem, r_dvd[7]};
    assign w_ge       = (w_rem_next >= {1'b0, r_dsr});
    assign w_sub      = w_rem_next[3:0] - r_dsr;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    w_next = (divisor == 4'h0) ? S_DONE : S_RUN;
                end else begin
                    w_next = S_IDLE;
                end
            end
            S_RUN: begin
                if (r_cnt == 3'd7) begin
                    w_next = S_DONE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_dvd       <= 8'h00;
            r_dsr       <= 4'h0;
            r_rem       <= 4'h0;
            r_quo       <= 8'h00;
            r_cnt       <= 3'd0;
            r_zero      <= 1'b0;
            r_done      <= 1'b0;
            r_quotient  <= 8'h00;
            r_remainder <= 4'h0;
            r_dbz       <= 1'b0;
        end else begin
            r_done <= (r_state == S_DONE);
            if (r_state == S_DONE) begin
                r_quotient  <= r_zero ? 8'hFF : r_quo;
                r_remainder <= r_zero ? 4'h0  : r_rem;
                r_dbz       <= r_zero;
            end
            if (w_accept) begin
                r_dvd  <= dividend;
                r_dsr  <= divisor;
                r_zero <= (divisor == 4'h0);
                r_rem  <= 4'h0;
                r_quo  <= 8'h00;
                r_cnt  <= 3'd0;
            end else if (r_state == S_RUN) begin
                r_dvd <= {r_dvd[6:0], 1'b0};
                r_rem <= w_ge ? w_sub : w_rem_next[3:0];
                r_quo <= {r_quo[6:0], w_ge};
                r_cnt <= r_cnt + 3'd1;
            end
        end
    end

`ifdef ARRAY_DIV_OVF_EN
    logic r_ovf;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ovf <= 1'b0;
        end else if (r_state == S_DONE) begin
            r_ovf <= !r_zero && (r_quo[7:4] != 4'h0);
        end
    end

    assign ovf = r_ovf;
`else
    assign ovf = 1'b0;
`endif

    assign busy      = (r_state == S_RUN);
    assign done      = r_done;
    assign quotient  = r_quotient;
    assign remainder = r_remainder;
    assign dbz       = r_dbz;

endmodule
`default_nettype wire

// File: tb/tb_array_div_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_array_div_seq
// Description : Self-checking bench for array_div_seq: cycle-by-cycle model
//               compare plus directed vectors with literal expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_array_div_seq;

`ifdef ARRAY_DIV_OVF_EN
    localparam logic OVF_ON = 1'b1;
`else
    localparam logic OVF_ON = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [7:0] dividend = 8'h00;
    logic [3:0] divisor = 4'h0;
    logic       busy, done, dbz, ovf;
    logic [7:0] quotient;
    logic [3:0] remainder;

    array_div_seq dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .dividend  (dividend),
        .divisor   (divisor),
        .busy      (busy),
        .done      (done),
        .quotient  (quotient),
        .remainder (remainder),
        .dbz       (dbz),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    // Behavioural model: timing in edge counts, results from plain / and %
    int         cyc = 0;
    int         free_at = 0;
    int         pend_at = 0;
    int         acc_at = -100;
    bit         pend = 1'b0;
    bit         pend_nz = 1'b0;
    logic [7:0] pq, eq = 8'h00;
    logic [3:0] pr, er = 4'h0;
    logic       pdbz, povf;
    logic       edbz = 1'b0, eovf = 1'b0, edone = 1'b0;

    always @(posedge clk) begin
        cyc++;
        edone = 1'b0;
        if (rst) begin
            pend = 1'b0; pend_nz = 1'b0; free_at = 0; acc_at = -100;
            eq = 8'h00; er = 4'h0; edbz = 1'b0; eovf = 1'b0;
        end else begin
            if (pend && cyc == pend_at) begin
                edone = 1'b1; eq = pq; er = pr; edbz = pdbz; eovf = povf; pend = 1'b0;
            end
            if (start && cyc >= free_at) begin
                if (divisor == 4'h0) begin
                    pq = 8'hFF; pr = 4'h0; pdbz = 1'b1; povf = 1'b0;
                    pend_at = cyc + 1; pend_nz = 1'b0;
                end else begin
                    pq = dividend / divisor;
                    pr = dividend % divisor;
                    pdbz = 1'b0;
                    povf = OVF_ON && (pq > 8'd15);
                    pend_at = cyc + 9; pend_nz = 1'b1;
                end
                free_at = pend_at; acc_at = cyc; pend = 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        logic ebusy;
        if (chk_en) begin
            ebusy = pend_nz && (cyc >= acc_at) && (cyc <= acc_at + 7);
            n_tests++;
            if (done !== edone || busy !== ebusy || quotient !== eq ||
                remainder !== er || dbz !== edbz || ovf !== eovf) begin
                n_fail++;
                $display("FAIL cycle%0d: done=%b/%b busy=%b/%b q=%h/%h r=%h/%h dbz=%b/%b ovf=%b/%b (got/expected)",
                         cyc, done, edone, busy, ebusy, quotient, eq, remainder, er, dbz, edbz, ovf, eovf);
            end
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic wait_done(input int k0, output int k);
        k = k0;
        while (done !== 1'b1 && k < 30) begin
            @(negedge clk);
            k++;
        end
    endtask

    task automatic op(input string name, input logic [7:0] a, input logic [3:0] b,
                      input logic [7:0] xq, input logic [3:0] xr,
                      input logic xdbz, input logic xovf, input int xlat);
        int k;
        @(negedge clk);
        start = 1'b1; dividend = a; divisor = b;
        @(negedge clk);
        start = 1'b0; dividend = 8'h55; divisor = 4'h3;
        wait_done(0, k);
        check({name, " latency"}, k, xlat);
        check({name, " quotient"}, quotient, xq);
        check({name, " remainder"}, remainder, xr);
        check({name, " dbz"}, dbz, xdbz);
        check({name, " ovf"}, ovf, xovf);
    endtask

    initial begin
        int k;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk_en = 1'b1;
        check("reset quotient", quotient, 8'h00);
        check("reset busy_done", {busy, done, dbz, ovf}, 4'b0000);

        op("exact",   8'h8F, 4'hD, 8'h0B, 4'h0, 1'b0, 1'b0,   9);
        op("ovf",     8'hC8, 4'h7, 8'h1C, 4'h4, 1'b0, OVF_ON, 9);
        op("max",     8'hFF, 4'h1, 8'hFF, 4'h0, 1'b0, OVF_ON, 9);
        op("small",   8'h03, 4'hF, 8'h00, 4'h3, 1'b0, 1'b0,   9);
        op("dbz",     8'h64, 4'h0, 8'hFF, 4'h0, 1'b1, 1'b0,   1);
        op("after",   8'h2A, 4'h6, 8'h07, 4'h0, 1'b0, 1'b0,   9);

        // start while busy is ignored
        @(negedge clk);
        start = 1'b1; dividend = 8'h8F; divisor = 4'hD;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        start = 1'b1; dividend = 8'h10; divisor = 4'h2;
        @(negedge clk);
        start = 1'b0;
        wait_done(4, k);
        check("ignore latency", k, 9);
        check("ignore result", {quotient, remainder}, {8'h0B, 4'h0});

        // back-to-back: start held through the DONE cycle
        @(negedge clk);
        start = 1'b1; dividend = 8'h8F; divisor = 4'hD;
        @(negedge clk);
        start = 1'b0;
        repeat (8) @(negedge clk);
        check("b2b busy low in DONE", busy, 1'b0);
        start = 1'b1; dividend = 8'h10; divisor = 4'h2;
        @(negedge clk);
        check("b2b first done", {done, quotient, remainder}, {1'b1, 8'h0B, 4'h0});
        @(negedge clk);
        start = 1'b0;
        wait_done(1, k);
        check("b2b second latency", k, 9);
        check("b2b second result", {quotient, remainder}, {8'h08, 4'h0});

        // reset mid-operation
        @(negedge clk);
        start = 1'b1; dividend = 8'h8F; divisor = 4'hD;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst outputs", {busy, done, quotient, remainder, dbz, ovf}, 16'h0000);
        repeat (12) @(negedge clk);
        op("post_rst", 8'hC8, 4'h7, 8'h1C, 4'h4, 1'b0, OVF_ON, 9);

        repeat (3) @(negedge clk);
        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
